// File: rtl/rxfifo_arb_pkg.sv
// rxfifo_arb_pkg
// Shared types and constants for the RX FIFO write arbiter.
//   arb_state_e           : arbiter FSM state (IDLE, XFER, DONE)
//   REQ_DESC/LINUX/BEACON : requester index assignment
//   STATS_*_W             : widths of the optional per-requester statistics counters
//   idx_width()           : index width for a requester count (never below 1)
package rxfifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam int unsigned REQ_DESC   = 0;
    localparam int unsigned REQ_LINUX  = 1;
    localparam int unsigned REQ_BEACON = 2;

    localparam int unsigned STATS_WORD_W  = 32;
    localparam int unsigned STATS_ABORT_W = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rxfifo_arb_rr_pick.sv
// rxfifo_arb_rr_pick
// Combinational round-robin pick: the first asserted requester at or after
// rr_ptr, wrapping modulo N_REQ.
//   req     : per-requester request vector
//   rr_ptr  : index that currently holds the highest priority
//   winner  : selected requester index (0 when nothing is requested)
//   any_req : at least one request is asserted
module rxfifo_arb_rr_pick
    import rxfifo_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 3,
    localparam int unsigned ID_W  = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  winner,
    output logic             any_req
);

    logic found;

    // Scan N_REQ positions starting at rr_ptr; the first hit wins.
    always_comb begin
        winner  = '0;
        any_req = |req;
        found   = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            int unsigned idx;
            idx = 32'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[ID_W'(idx)]) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rxfifo_wr_arbiter.sv
// rxfifo_wr_arbiter
// Arbitrates burst writes from N_REQ requesters (descriptor, linux, beacon)
// into a single RX FIFO. A granted burst runs to its last word or until the
// stall timeout fires; bursts are never preempted. Grants rotate round-robin.
//
// Ports
//   clk, reset_n        : clock, synchronous active-low reset
//   req/req_data/req_last : per-requester word valid, word, end-of-burst
//   req_ack             : combinational word-accepted strobe
//   req_done/req_abort  : one-cycle burst complete / aborted pulses
//   rxfifo_full/overflow: FIFO status inputs
//   rxfifo_wr_en/dwrite : FIFO write port, one cycle after acceptance
//   grant_valid/grant_id: current burst owner
//   overflow_err        : sticky, set by any rxfifo_overflow
//
// Optional feature: define RXFIFO_ARB_STATS_EN to add word_cnt (32 bits per
// requester, counts accepted words) and abort_cnt (16 bits per requester,
// counts aborted bursts).
module rxfifo_wr_arbiter
    import rxfifo_arb_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH    = 32,
    parameter  int unsigned N_REQ         = 3,
    parameter  int unsigned STALL_TIMEOUT = 64,
    localparam int unsigned ID_W          = idx_width(N_REQ)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ack,
    output logic [N_REQ-1:0]            req_done,
    output logic [N_REQ-1:0]            req_abort,
    input  logic                        rxfifo_full,
    input  logic                        rxfifo_overflow,
    output logic                        rxfifo_wr_en,
    output logic [DATA_WIDTH-1:0]       rxfifo_dwrite,
    output logic                        grant_valid,
    output logic [ID_W-1:0]             grant_id,
    output logic                        overflow_err
`ifdef RXFIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*STATS_WORD_W-1:0]  word_cnt,
    output logic [N_REQ*STATS_ABORT_W-1:0] abort_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);

    arb_state_e            state_q;
    arb_state_e            state_d;
    logic [ID_W-1:0]       rr_ptr_q;
    logic [ID_W-1:0]       rr_ptr_d;
    logic [CNT_W-1:0]      stall_q;
    logic [CNT_W-1:0]      stall_d;

    logic [ID_W-1:0]       winner;
    logic                  any_req;

    logic                  sel_req;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;
    logic                  timeout_hit;

    logic                  grant_valid_d;
    logic [ID_W-1:0]       grant_id_d;
    logic                  wr_en_d;
    logic [DATA_WIDTH-1:0] dwrite_d;
    logic [N_REQ-1:0]      done_d;
    logic [N_REQ-1:0]      abort_d;

    rxfifo_arb_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // Signals of the requester that owns the current grant.
    assign sel_req  = req[grant_id];
    assign sel_last = req_last[grant_id];
    assign sel_data = req_data[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

    // Word acceptance; held off during reset so no ack escapes.
    assign accept = reset_n && (state_q == XFER) && sel_req && !rxfifo_full;

    // This non-accepting cycle would bring the stall count to STALL_TIMEOUT.
    assign timeout_hit = (state_q == XFER) && !accept &&
                         (stall_q == CNT_W'(STALL_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if ((accept && sel_last) || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: combinational ack plus next values of registered outputs.
    always_comb begin
        req_ack       = '0;
        wr_en_d       = accept;
        dwrite_d      = accept ? sel_data : rxfifo_dwrite;
        grant_valid_d = grant_valid;
        grant_id_d    = grant_id;
        rr_ptr_d      = rr_ptr_q;
        stall_d       = stall_q;
        done_d        = '0;
        abort_d       = '0;

        if (accept) begin
            req_ack[grant_id] = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                stall_d = '0;
                if (any_req) begin
                    grant_valid_d = 1'b1;
                    grant_id_d    = winner;
                end
            end
            XFER: begin
                // Any non-accepting cycle counts, whether req is low or FIFO is full.
                stall_d = accept ? '0 : stall_q + CNT_W'(1);
                if (accept && sel_last) begin
                    done_d[grant_id] = 1'b1;
                end else if (timeout_hit) begin
                    abort_d[grant_id] = 1'b1;
                end
            end
            DONE: begin
                stall_d       = '0;
                grant_valid_d = 1'b0;
                rr_ptr_d      = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
            default: begin
                stall_d = '0;
            end
        endcase
    end

    // Registered outputs and bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q      <= '0;
            stall_q       <= '0;
            grant_valid   <= 1'b0;
            grant_id      <= '0;
            rxfifo_wr_en  <= 1'b0;
            rxfifo_dwrite <= '0;
            req_done      <= '0;
            req_abort     <= '0;
            overflow_err  <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            stall_q       <= stall_d;
            grant_valid   <= grant_valid_d;
            grant_id      <= grant_id_d;
            rxfifo_wr_en  <= wr_en_d;
            rxfifo_dwrite <= dwrite_d;
            req_done      <= done_d;
            req_abort     <= abort_d;
            overflow_err  <= overflow_err | rxfifo_overflow;
        end
    end

`ifdef RXFIFO_ARB_STATS_EN
    // Per-requester wrapping statistics.
    for (genvar i = 0; i < N_REQ; i++) begin : g_stats
        logic [STATS_WORD_W-1:0]  words_q;
        logic [STATS_ABORT_W-1:0] aborts_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                words_q  <= '0;
                aborts_q <= '0;
            end else begin
                if (req_ack[i]) begin
                    words_q <= words_q + STATS_WORD_W'(1);
                end
                if (req_abort[i]) begin
                    aborts_q <= aborts_q + STATS_ABORT_W'(1);
                end
            end
        end

        assign word_cnt[i*STATS_WORD_W +: STATS_WORD_W]    = words_q;
        assign abort_cnt[i*STATS_ABORT_W +: STATS_ABORT_W] = aborts_q;
    end
`endif

endmodule

// File: tb/tb_rxfifo_wr_arbiter.sv
// tb_rxfifo_wr_arbiter
// Scoreboard bench: stimulus pushes expected FIFO words and burst events into
// queues using a round-robin service-order model; a monitor pops and compares
// on every rxfifo_wr_en and every req_done/req_abort pulse.
module tb_rxfifo_wr_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 3;
    localparam int unsigned TO = 64;
    localparam int          EVT_ABORT = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ack;
    logic [NR-1:0]     req_done;
    logic [NR-1:0]     req_abort;
    logic              rxfifo_full;
    logic              rxfifo_overflow;
    logic              rxfifo_wr_en;
    logic [DW-1:0]     rxfifo_dwrite;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic              overflow_err;
`ifdef RXFIFO_ARB_STATS_EN
    logic [NR*32-1:0]  word_cnt;
    logic [NR*16-1:0]  abort_cnt;
`endif

    rxfifo_wr_arbiter #(
        .DATA_WIDTH    (DW),
        .N_REQ         (NR),
        .STALL_TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req             (req),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ack         (req_ack),
        .req_done        (req_done),
        .req_abort       (req_abort),
        .rxfifo_full     (rxfifo_full),
        .rxfifo_overflow (rxfifo_overflow),
        .rxfifo_wr_en    (rxfifo_wr_en),
        .rxfifo_dwrite   (rxfifo_dwrite),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id),
        .overflow_err    (overflow_err)
`ifdef RXFIFO_ARB_STATS_EN
        ,
        .word_cnt        (word_cnt),
        .abort_cnt       (abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Requester-side burst state.
    logic [DW-1:0] words [NR][16];
    int  blen [NR];
    int  bptr [NR];
    int  acks [NR];
    bit  ghost [NR];
    int  ghost_cnt [NR];
    bit  rnd_en = 1'b0;
    int  full_hold = 0;

    // Scoreboard and monitor state.
    logic [DW-1:0] exp_wr[$];
    int  exp_evt[$];
    int  wr_cyc[$];
    int  model_rr = 0;
    int  cyc = 0;
    int  wr_cnt = 0;
    bit  sb_bypass = 1'b0;
    bit  watch = 1'b0;
    int  early_ack0 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic load_burst(input int i, input int n, input bit gh);
        for (int w = 0; w < n; w++) words[i][w] = $urandom;
        blen[i]      = n;
        bptr[i]      = 0;
        acks[i]      = 0;
        ghost[i]     = gh;
        ghost_cnt[i] = -1;
    endtask

    // Reference model: requesters in mask all pending together; serve them in
    // round-robin order from model_rr, each burst yielding its words then an event.
    task automatic model_push(input int mask);
        int m;
        m = mask;
        while (m != 0) begin
            int g;
            g = -1;
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (model_rr + k) % NR;
                if (g < 0 && m[idx]) g = idx;
            end
            if (ghost[g]) begin
                exp_evt.push_back(EVT_ABORT + g);
            end else begin
                for (int w = 0; w < blen[g]; w++) exp_wr.push_back(words[g][w]);
                exp_evt.push_back(g);
            end
            model_rr = (g + 1) % NR;
            m = m & ~(1 << g);
        end
    endtask

    // One negedge of requester/FIFO driving, then observe the combinational ack.
    task automatic drive_cycle();
        logic [NR-1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) begin
            bit drop;
            drop = 1'b0;
            if (ghost[i] && bptr[i] < blen[i]) begin
                if (req_abort[i]) bptr[i] = blen[i];
                else if (ghost_cnt[i] < 0 && grant_valid && grant_id == i) ghost_cnt[i] = TO + 16;
            end
            if (bptr[i] < blen[i]) begin
                if (ghost_cnt[i] > 0) begin
                    drop = 1'b1;
                    ghost_cnt[i]--;
                end else if (rnd_en && acks[i] > 0 && $urandom_range(99) < 15) begin
                    drop = 1'b1;
                end
                r[i] = !drop;
                req_data[i*DW +: DW] = words[i][bptr[i]];
                req_last[i] = (bptr[i] == blen[i] - 1);
            end else begin
                req_last[i] = 1'b0;
            end
        end
        req = r;
        rxfifo_full = (full_hold > 0) ? 1'b1 : (rnd_en && $urandom_range(99) < 25);
        if (full_hold > 0) full_hold--;
        #1;
        if (req_ack != '0) begin
            check("ack_onehot", 64'($countones(req_ack)), 64'd1);
            check("ack_without_req", 64'(req_ack & ~req), 64'd0);
            if (watch && req_ack[0] && bptr[1] < blen[1]) early_ack0++;
            for (int i = 0; i < NR; i++) begin
                if (req_ack[i] && bptr[i] < blen[i]) begin
                    bptr[i]++;
                    acks[i]++;
                end
            end
        end
    endtask

    initial begin
        req = '0;
        req_data = '0;
        req_last = '0;
        rxfifo_full = 1'b0;
        forever begin
            @(negedge clk);
            drive_cycle();
        end
    end

    task automatic got_evt(input int e);
        if (exp_evt.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL burst_event_unexpected: got %0d required none", e);
        end else begin
            check("burst_event", 64'(e), 64'(exp_evt.pop_front()));
        end
    endtask

    // Monitor: samples just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rxfifo_wr_en) begin
                wr_cnt++;
                wr_cyc.push_back(cyc);
                if (!sb_bypass) begin
                    if (exp_wr.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL wr_unexpected: got %0h required no write", rxfifo_dwrite);
                    end else begin
                        check("wr_data", 64'(rxfifo_dwrite), 64'(exp_wr.pop_front()));
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_done[i])  got_evt(i);
                if (req_abort[i]) got_evt(EVT_ABORT + i);
            end
        end
    end

    task automatic sync_pre();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t;
        t = 0;
        while ((exp_wr.size() != 0 || exp_evt.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (exp_wr.size() != 0 || exp_evt.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d words %0d events pending required 0",
                     name, exp_wr.size(), exp_evt.size());
            exp_wr.delete();
            exp_evt.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_acks(input int i, input int n, input int budget);
        int t;
        t = 0;
        while (acks[i] < n && t < budget) begin
            sync_pre();
            t++;
        end
        if (acks[i] < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_acks%0d: got %0d required %0d", i, acks[i], n);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_wr_en"},       64'(rxfifo_wr_en),  64'd0);
        check({name, "_dwrite"},      64'(rxfifo_dwrite), 64'd0);
        check({name, "_grant_valid"}, 64'(grant_valid),   64'd0);
        check({name, "_grant_id"},    64'(grant_id),      64'd0);
        check({name, "_done"},        64'(req_done),      64'd0);
        check({name, "_abort"},       64'(req_abort),     64'd0);
        check({name, "_ovf_err"},     64'(overflow_err),  64'd0);
        check({name, "_ack"},         64'(req_ack),       64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int base;
        int mask;
        int t;
        for (int i = 0; i < NR; i++) begin
            blen[i] = 0;
            bptr[i] = 0;
            acks[i] = 0;
            ghost[i] = 1'b0;
            ghost_cnt[i] = -1;
        end
        reset_n = 1'b0;
        rxfifo_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Simultaneous requests 0 and 1, two words each.
        sync_pre();
        load_burst(0, 2, 1'b0);
        load_burst(1, 2, 1'b0);
        model_push(3);
        t0 = cyc;
        wr_cyc.delete();
        wait_drain("rr_pair", 100);
        check("rr_pair_nwrites", 64'(wr_cyc.size()), 64'd4);
        if (wr_cyc.size() >= 4) begin
            check("rr_pair_cyc0", 64'(wr_cyc[0] - t0), 64'd2);
            check("rr_pair_cyc1", 64'(wr_cyc[1] - t0), 64'd3);
            check("rr_pair_cyc2", 64'(wr_cyc[2] - t0), 64'd6);
            check("rr_pair_cyc3", 64'(wr_cyc[3] - t0), 64'd7);
        end

        // All three request: priority now starts at requester 2.
        sync_pre();
        for (int i = 0; i < NR; i++) load_burst(i, 1, 1'b0);
        model_push(7);
        wait_drain("rr_all", 100);

        // Requester 1, four words, FIFO full for 5 cycles after word 2.
        sync_pre();
        load_burst(1, 4, 1'b0);
        model_push(2);
        base = wr_cnt;
        wait_acks(1, 2, 40);
        full_hold = 5;
        wait_drain("full_stall", 100);
        check("full_stall_nwrites", 64'(wr_cnt - base), 64'd4);

        // Requester 2 granted then silent: abort, then priority returns to 0.
        sync_pre();
        load_burst(2, 2, 1'b1);
        model_push(4);
        wait_drain("timeout", 300);
        sync_pre();
        load_burst(0, 1, 1'b0);
        load_burst(2, 1, 1'b0);
        model_push(5);
        wait_drain("after_abort", 100);

        // Requester 0 arrives mid-burst of requester 1 and must wait.
        rnd_en = 1'b1;
        sync_pre();
        load_burst(1, 6, 1'b0);
        model_push(2);
        wait_acks(1, 2, 60);
        load_burst(0, 1, 1'b0);
        model_push(1);
        watch = 1'b1;
        early_ack0 = 0;
        wait_drain("no_preempt", 300);
        watch = 1'b0;
        check("no_preempt_ack0", 64'(early_ack0), 64'd0);

        // Single overflow pulse is sticky.
        @(negedge clk);
        rxfifo_overflow = 1'b1;
        @(negedge clk);
        rxfifo_overflow = 1'b0;
        repeat (5) @(negedge clk);
        check("overflow_sticky", 64'(overflow_err), 64'd1);

        // Randomized request sets with random FIFO full and mid-burst gaps.
        repeat (40) begin
            sync_pre();
            mask = $urandom_range(1, 7);
            for (int i = 0; i < NR; i++) begin
                if (mask[i]) load_burst(i, $urandom_range(1, 5), 1'b0);
            end
            model_push(mask);
            wait_drain("random", 400);
        end

        // Reset in the middle of a burst drops it with no pulse.
        rnd_en = 1'b0;
        sb_bypass = 1'b1;
        sync_pre();
        load_burst(0, 8, 1'b0);
        base = wr_cnt;
        t = 0;
        while (wr_cnt - base < 2 && t < 40) begin
            sync_pre();
            t++;
        end
        @(negedge clk);
        reset_n = 1'b0;
        sync_pre();
        check_idle_outputs("mid_reset");
        bptr[0] = blen[0];
        @(negedge clk);
        reset_n = 1'b1;
        model_rr = 0;
        repeat (10) @(negedge clk);
        sb_bypass = 1'b0;

`ifdef RXFIFO_ARB_STATS_EN
        repeat (3) begin
            sync_pre();
            load_burst(0, 1, 1'b0);
            model_push(1);
            wait_drain("stats", 100);
        end
        check("word_cnt0", 64'(word_cnt[31:0]), 64'd3);
        check("abort_cnt", 64'(abort_cnt), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
